hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, taken-branch flush, mul/div hold in ID.
// Latency: outputs are combinational from state + inputs (same-cycle stall); state/counters registered.
// Backpressure: holds PC and IF/ID (PC_En/IFID_En low) and bubbles ID/EX while a hazard is pending.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ID_Rs1/ID_Rs2/ID_Use_*   source registers of the ID instruction and whether each is read
//   ID_MD_Op                 ID instruction is a multi-cycle mul/div
//   EX_Rd/EX_MemRead         destination of the EX instruction and whether it is a load
//   EX_Branch_Taken          branch/jump in EX resolved taken
//   PC_En/IFID_En            PC and IF/ID write enables
//   IFID_Flush/IDEX_Flush    clear IF/ID, bubble ID/EX
//   MD_Done                  one-cycle pulse when a mul/div op is released from ID
//   stall_count              saturating count of cycles with PC_En=0
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_Use_Rs1,
  input  logic                  ID_Use_Rs2,
  input  logic                  ID_MD_Op,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_MemRead,
  input  logic                  EX_Branch_Taken,
  output logic                  PC_En,
  output logic                  IFID_En,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush,
  output logic                  MD_Done,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  // md_cnt only ever holds 0..MD_LATENCY-1
  localparam int MDW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MDW-1:0] MD_INIT = MDW'(MD_LATENCY - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t               r_state, w_next_state;
  logic [MDW-1:0]       r_md_cnt, w_next_md_cnt;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic                 w_load_use;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer
  assign w_load_use = EX_MemRead && (EX_Rd != '0) &&
                      ((ID_Use_Rs1 && (ID_Rs1 == EX_Rd)) ||
                       (ID_Use_Rs2 && (ID_Rs2 == EX_Rd)));

  always_comb begin
    w_next_state  = r_state;
    w_next_md_cnt = r_md_cnt;
    PC_En         = 1'b1;
    IFID_En       = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Flush    = 1'b0;
    MD_Done       = 1'b0;

    if (rst) begin
      // reset drives a fully frozen, flushed pipeline without waiting for a clock
      PC_En         = 1'b0;
      IFID_En       = 1'b0;
      IFID_Flush    = 1'b1;
      IDEX_Flush    = 1'b1;
      w_next_state  = RUN;
      w_next_md_cnt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (EX_Branch_Taken) begin
            // wrong-path ID instruction is discarded, so its hazards do not matter
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (w_load_use) begin
            // one-cycle stall; the load moves on and the hazard disappears by itself
            PC_En      = 1'b0;
            IFID_En    = 1'b0;
            IDEX_Flush = 1'b1;
          end else if (ID_MD_Op) begin
            PC_En         = 1'b0;
            IFID_En       = 1'b0;
            IDEX_Flush    = 1'b1;
            w_next_md_cnt = MD_INIT;
            w_next_state  = MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (EX_Branch_Taken) begin
            // abnormal abort: drop the held op without a completion pulse
            IFID_Flush    = 1'b1;
            IDEX_Flush    = 1'b1;
            w_next_md_cnt = '0;
            w_next_state  = RUN;
          end else if (r_md_cnt != '0) begin
            PC_En         = 1'b0;
            IFID_En       = 1'b0;
            IDEX_Flush    = 1'b1;
            w_next_md_cnt = r_md_cnt - MDW'(1);
          end else begin
            MD_Done      = 1'b1;
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state  = RUN;
          w_next_md_cnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_md_cnt      <= '0;
      r_stall_count <= '0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_next_md_cnt;
      if (!PC_En && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use1, id_use2, id_md, ex_mr, ex_br;

  logic        pc_en, ifid_en, ifid_fl, idex_fl, md_done;
  logic [15:0] cnt16;
  logic        pc_en_b, ifid_en_b, ifid_fl_b, idex_fl_b, md_done_b;
  logic [3:0]  cnt4;

  hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(MD_LAT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs1(id_rs1), .ID_Rs2(id_rs2), .ID_Use_Rs1(id_use1), .ID_Use_Rs2(id_use2),
    .ID_MD_Op(id_md), .EX_Rd(ex_rd), .EX_MemRead(ex_mr), .EX_Branch_Taken(ex_br),
    .PC_En(pc_en), .IFID_En(ifid_en), .IFID_Flush(ifid_fl), .IDEX_Flush(idex_fl),
    .MD_Done(md_done), .stall_count(cnt16)
  );

  // narrow-counter instance to exercise saturation
  hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(MD_LAT), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .ID_Rs1(id_rs1), .ID_Rs2(id_rs2), .ID_Use_Rs1(id_use1), .ID_Use_Rs2(id_use2),
    .ID_MD_Op(id_md), .EX_Rd(ex_rd), .EX_MemRead(ex_mr), .EX_Branch_Taken(ex_br),
    .PC_En(pc_en_b), .IFID_En(ifid_en_b), .IFID_Flush(ifid_fl_b), .IDEX_Flush(idex_fl_b),
    .MD_Done(md_done_b), .stall_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {pc_en, ifid_en, ifid_fl, idex_fl, md_done};
  endfunction

  // ---- reference model: md_age = cycles elapsed since the mul/div op was detected (0 = none)
  int         m_age, m_next_age, m_cnt16, m_cnt4;
  logic [4:0] e_outs;

  task automatic calc();
    bit lu;
    lu = ex_mr && (ex_rd != 0) &&
         ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
    e_outs     = 5'b11000;
    m_next_age = 0;
    if (ex_br)                 e_outs = 5'b11110;
    else if (m_age == 0) begin
      if (lu)                  e_outs = 5'b00010;
      else if (id_md) begin    e_outs = 5'b00010; m_next_age = 1; end
    end
    else if (m_age < MD_LAT) begin e_outs = 5'b00010; m_next_age = m_age + 1; end
    else                       e_outs = 5'b11001;
  endtask

  task automatic settle();
    #2;
    calc();
    chk("outputs", 32'(outs()), 32'(e_outs));
    chk("outputs_w4", 32'({pc_en_b, ifid_en_b, ifid_fl_b, idex_fl_b, md_done_b}), 32'(e_outs));
    chk("stall_count", 32'(cnt16), 32'(m_cnt16));
    chk("stall_count_w4", 32'(cnt4), 32'(m_cnt4));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!e_outs[4]) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
    end
    m_age = m_next_age;
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic md, input logic [4:0] rd, input logic mr, input logic br);
    id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_md = md; ex_rd = rd; ex_mr = mr; ex_br = br;
  endtask

  // ---- directed table: inputs + expected {PC_En,IFID_En,IFID_Flush,IDEX_Flush,MD_Done} + stall_count
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, md, mr, br;
    logic [4:0]  exp_o;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic md, input logic [4:0] rd,
                              input logic mr, input logic br, input logic [4:0] eo,
                              input logic [15:0] ec);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.md = md;
    v.rd = rd; v.mr = mr; v.br = br; v.exp_o = eo; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    // idle / load-use / x0 / unused rs2 / branch priority / idle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0));
    tbl.push_back(mk(5, 1, 0, 0, 0, 5, 1, 0, 5'b00010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 0, 7, 0, 0, 7, 1, 0, 5'b11000, 1));
    tbl.push_back(mk(5, 1, 0, 0, 1, 5, 1, 1, 5'b11110, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1));
    // MD op held: 4 stalls then release with MD_Done
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00010, 16'(1 + k)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b11001, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5));
    // load x3 then MD op reading x3 via rs2: 1 load stall + 4 MD stalls, release on cycle 6
    tbl.push_back(mk(0, 0, 3, 1, 1, 3, 1, 0, 5'b00010, 5));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 3, 1, 1, 0, 0, 0, 5'b00010, 16'(6 + k)));
    tbl.push_back(mk(0, 0, 3, 1, 1, 0, 0, 0, 5'b11001, 10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 10));

    m_age = 0; m_cnt16 = 0; m_cnt4 = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #3;
    chk("reset_outs", 32'(outs()), 32'(5'b00110));
    chk("reset_cnt", 32'(cnt16), 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      set_in(tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].md, tbl[i].rd, tbl[i].mr, tbl[i].br);
      settle();
      chk($sformatf("tbl%0d_outs", i), 32'(outs()), 32'(tbl[i].exp_o));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt16), 32'(tbl[i].exp_cnt));
      tick();
    end

    // abort: branch taken during the second MD_WAIT cycle
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    settle(); tick();
    settle(); tick();
    ex_br = 1'b1;
    settle();
    chk("abort_flush", 32'(outs()), 32'(5'b11110));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("abort_run_no_done", 32'(outs()), 32'(5'b11000));
    tick();

    // asynchronous reset between edges while in MD_WAIT
    id_md = 1'b1;
    settle(); tick();
    settle();
    rst = 1'b1;
    #1;
    chk("arst_outs", 32'(outs()), 32'(5'b00110));
    chk("arst_cnt", 32'(cnt16), 0);
    chk("arst_cnt4", 32'(cnt4), 0);
    m_age = 0; m_cnt16 = 0; m_cnt4 = 0;
    @(posedge clk); #1;
    chk("arst_hold_cnt", 32'(cnt16), 0);
    rst = 1'b0;
    id_md = 1'b0;
    settle();
    chk("arst_release_no_done", 32'(outs()), 32'(5'b11000));
    tick();

    // saturation: 20 consecutive load-use stalls
    set_in(9, 1, 0, 0, 0, 9, 1, 0);
    for (int k = 0; k < 20; k++) begin settle(); tick(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("sat_cnt4", 32'(cnt4), 15);
    chk("sat_cnt16", 32'(cnt16), 20);
    tick();

    // randomized traffic against the model; small register range keeps hazards frequent
    for (int k = 0; k < 400; k++) begin
      set_in(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom_range(0, 7) == 0));
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
